// File: rtl/mmio_timer_pkg.sv
// rtl/mmio_timer_pkg.sv - register offsets, CTRL bit indices and bus size encodings
// Size encodings are shared with the RAM's size decode.
package mmio_timer_pkg;

  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_COUNT    = 3'd1;
  localparam logic [2:0] REG_COMPARE  = 3'd2;
  localparam logic [2:0] REG_STATUS   = 3'd3;
  localparam logic [2:0] REG_PRESCALE = 3'd4;

  localparam int CTRL_EN = 0;
  localparam int CTRL_AR = 1;
  localparam int CTRL_IE = 2;

  localparam logic [1:0] SEL_WORD = 2'b00;
  localparam logic [1:0] SEL_HALF = 2'b01;
  localparam logic [1:0] SEL_BYTE = 2'b10;

endpackage

// File: rtl/mmio_lane_merge.sv
// rtl/mmio_lane_merge.sv - byte/half lane insert for writes and extract for reads
// Unaligned word/half addresses are aligned by ignoring the low address bits.
module mmio_lane_merge
  import mmio_timer_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            sel,
  input  logic [1:0]            addr_lo,
  input  logic [DATA_WIDTH-1:0] old_word,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] merged,
  output logic [DATA_WIDTH-1:0] wmask,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] pos;
  logic [4:0]            half_sh;
  logic [4:0]            byte_sh;

  assign half_sh = {addr_lo[1], 4'b0000};
  assign byte_sh = {addr_lo, 3'b000};

  always_comb begin
    wmask = '1;
    pos   = wdata;
    rdata = old_word;
    case (sel)
      SEL_HALF: begin
        wmask = {{(DATA_WIDTH-16){1'b0}}, 16'hFFFF} << half_sh;
        pos   = {{(DATA_WIDTH-16){1'b0}}, wdata[15:0]} << half_sh;
        rdata = (old_word >> half_sh) & {{(DATA_WIDTH-16){1'b0}}, 16'hFFFF};
      end
      SEL_BYTE: begin
        wmask = {{(DATA_WIDTH-8){1'b0}}, 8'hFF} << byte_sh;
        pos   = {{(DATA_WIDTH-8){1'b0}}, wdata[7:0]} << byte_sh;
        rdata = (old_word >> byte_sh) & {{(DATA_WIDTH-8){1'b0}}, 8'hFF};
      end
      default: ;
    endcase
  end

  assign merged = (old_word & ~wmask) | (pos & wmask);

endmodule

// File: rtl/mmio_timer.sv
// rtl/mmio_timer.sv - memory-mapped prescaled timer with compare match and interrupt
// Register file, address decode and prescaler/counter datapath.
module mmio_timer
  import mmio_timer_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = 32'hFFFF_0000
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [ADDRESS_WIDTH-1:0] Addr,
  input  logic [DATA_WIDTH-1:0]    Data,
  input  logic                     W_EN,
  input  logic [1:0]               sel,
  output logic                     Hit,
  output logic [DATA_WIDTH-1:0]    Output_Data,
  output logic                     IRQ
);

  localparam logic [DATA_WIDTH-1:0] ONE    = 1;
  localparam logic [DATA_WIDTH-1:0] BIT0_M = 1;

  logic [2:0]            ctrl_q, ctrl_d;
  logic [DATA_WIDTH-1:0] count_q, count_d;
  logic [DATA_WIDTH-1:0] compare_q, compare_d;
  logic                  match_q, match_d;
  logic [15:0]           prescale_q, prescale_d;
  logic [15:0]           pcnt_q, pcnt_d;

  logic [2:0]            reg_idx;
  logic [DATA_WIDTH-1:0] reg_rd, merged, wmask, rdata;
  logic                  wr, tick, match_set;

  assign Hit     = (Addr[ADDRESS_WIDTH-1:5] == BASE_ADDR[ADDRESS_WIDTH-1:5]);
  assign reg_idx = Addr[4:2];
  assign wr      = W_EN & Hit;

  always_comb begin
    reg_rd = '0;
    case (reg_idx)
      REG_CTRL:     reg_rd = {{(DATA_WIDTH-3){1'b0}}, ctrl_q};
      REG_COUNT:    reg_rd = count_q;
      REG_COMPARE:  reg_rd = compare_q;
      REG_STATUS:   reg_rd = {{(DATA_WIDTH-1){1'b0}}, match_q};
      REG_PRESCALE: reg_rd = {{(DATA_WIDTH-16){1'b0}}, prescale_q};
      default:      reg_rd = '0;
    endcase
  end

  mmio_lane_merge #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
    .sel     (sel),
    .addr_lo (Addr[1:0]),
    .old_word(reg_rd),
    .wdata   (Data),
    .merged  (merged),
    .wmask   (wmask),
    .rdata   (rdata)
  );

  assign Output_Data = Hit ? rdata : '0;
  assign IRQ         = match_q & ctrl_q[CTRL_IE];

  assign tick      = ctrl_q[CTRL_EN] && (pcnt_q == prescale_q);
  assign match_set = tick && (count_q == compare_q);

  always_comb begin
    ctrl_d     = ctrl_q;
    count_d    = count_q;
    compare_d  = compare_q;
    match_d    = match_q;
    prescale_d = prescale_q;
    pcnt_d     = pcnt_q;

    if (ctrl_q[CTRL_EN]) pcnt_d = tick ? 16'd0 : pcnt_q + 16'd1;
    if (tick) count_d = (match_set && ctrl_q[CTRL_AR]) ? '0 : count_q + ONE;

    // Bus writes override the tick update; a fresh match still beats W1C below.
    if (wr) begin
      case (reg_idx)
        REG_CTRL: begin
          ctrl_d = merged[2:0];
          if (merged[CTRL_EN] && !ctrl_q[CTRL_EN]) pcnt_d = 16'd0;
        end
        REG_COUNT:    count_d    = merged;
        REG_COMPARE:  compare_d  = merged;
        REG_STATUS:   if ((wmask & merged & BIT0_M) != '0) match_d = 1'b0;
        REG_PRESCALE: prescale_d = merged[15:0];
        default: ;
      endcase
    end
    if (match_set) match_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ctrl_q     <= '0;
      count_q    <= '0;
      compare_q  <= '0;
      match_q    <= 1'b0;
      prescale_q <= '0;
      pcnt_q     <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      match_q    <= match_d;
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// tb/tb_mmio_timer.sv - directed scoreboard bench for mmio_timer
module tb_mmio_timer;

  localparam logic [31:0] B = 32'hFFFF_0000;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] Addr;
  logic [31:0] Data;
  logic        W_EN;
  logic [1:0]  sel;
  logic        Hit;
  logic [31:0] Output_Data;
  logic        IRQ;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb_q[$];

  always #5 CLK = ~CLK;

  mmio_timer #(
    .ADDRESS_WIDTH(32),
    .DATA_WIDTH   (32),
    .BASE_ADDR    (B)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .Addr       (Addr),
    .Data       (Data),
    .W_EN       (W_EN),
    .sel        (sel),
    .Hit        (Hit),
    .Output_Data(Output_Data),
    .IRQ        (IRQ)
  );

  task automatic expect_push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic compare_pop(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h expected=none", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic rd(input string tag, input logic [4:0] off, input logic [1:0] s,
                    input logic [31:0] exp);
    Addr = B | {27'd0, off};
    sel  = s;
    W_EN = 1'b0;
    expect_push(tag, exp);
    #1;
    compare_pop(Output_Data);
  endtask

  task automatic chk_irq(input string tag, input logic e);
    expect_push(tag, {31'd0, e});
    #1;
    compare_pop({31'd0, IRQ});
  endtask

  task automatic wr(input logic [4:0] off, input logic [31:0] d, input logic [1:0] s);
    Addr = B | {27'd0, off};
    Data = d;
    sel  = s;
    W_EN = 1'b1;
    @(posedge CLK);
    #1;
    W_EN = 1'b0;
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int seq [5];
    seq  = '{0, 1, 2, 3, 0};
    RST  = 1'b0;
    Addr = '0;
    Data = '0;
    W_EN = 1'b0;
    sel  = 2'b00;
    #2;

    // reset state and window decode
    for (int i = 0; i < 8; i++) rd($sformatf("reset_off_%0h", i * 4), 5'(i * 4), 2'b00, 32'd0);
    chk_irq("reset_irq", 1'b0);
    Addr = 32'h1000_0000;
    expect_push("miss_data", 32'd0);
    expect_push("miss_hit", 32'd0);
    #1;
    compare_pop(Output_Data);
    compare_pop({31'd0, Hit});
    Addr = B | 32'h1C;
    expect_push("in_window_hit", 32'd1);
    #1;
    compare_pop({31'd0, Hit});
    cyc();
    RST = 1'b1;
    cyc();

    // basic compare match, AR=0
    wr(5'h08, 32'd5, 2'b00);
    wr(5'h00, 32'h5, 2'b00);
    for (int i = 0; i < 6; i++) begin
      rd($sformatf("basic_count_%0d", i), 5'h04, 2'b00, 32'(i));
      rd($sformatf("basic_status_%0d", i), 5'h0C, 2'b00, 32'd0);
      chk_irq($sformatf("basic_irq_%0d", i), 1'b0);
      cyc();
    end
    rd("basic_count_after", 5'h04, 2'b00, 32'd6);
    rd("basic_match", 5'h0C, 2'b00, 32'd1);
    chk_irq("basic_irq_set", 1'b1);
    wr(5'h00, 32'h0, 2'b00);
    wr(5'h0C, 32'h1, 2'b00);

    // auto-reload with prescale 2
    wr(5'h04, 32'd0, 2'b00);
    wr(5'h08, 32'd3, 2'b00);
    wr(5'h10, 32'd2, 2'b00);
    wr(5'h00, 32'h3, 2'b00);
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 3; c++) begin
        rd($sformatf("ar_count_%0d_%0d", k, c), 5'h04, 2'b00, 32'(seq[k]));
        if (c == 0) rd($sformatf("ar_status_%0d", k), 5'h0C, 2'b00, {31'd0, k == 4});
        cyc();
      end
    end
    wr(5'h00, 32'h0, 2'b00);

    // lane access
    wr(5'h04, 32'h1122_3344, 2'b00);
    wr(5'h05, 32'h0000_00AB, 2'b10);
    rd("byte_write_word", 5'h04, 2'b00, 32'h1122_AB44);
    rd("half_read_hi", 5'h06, 2'b01, 32'h0000_1122);
    rd("byte_read_3", 5'h07, 2'b10, 32'h0000_0011);
    rd("sel11_unaligned", 5'h06, 2'b11, 32'h1122_AB44);
    wr(5'h0B, 32'hDEAD_BEEF, 2'b01);
    rd("half_write_hi", 5'h08, 2'b00, 32'hBEEF_0003);
    wr(5'h14, 32'hFFFF_FFFF, 2'b00);
    rd("reserved_read", 5'h14, 2'b00, 32'd0);
    wr(5'h10, 32'hFFFF_1234, 2'b00);
    rd("prescale_16b", 5'h10, 2'b00, 32'h0000_1234);

    // W1C colliding with a new match, then COUNT write on a tick edge
    wr(5'h10, 32'd0, 2'b00);
    wr(5'h04, 32'd0, 2'b00);
    wr(5'h08, 32'd2, 2'b00);
    wr(5'h00, 32'h5, 2'b00);
    cyc();
    cyc();
    rd("coll_count_pre", 5'h04, 2'b00, 32'd2);
    wr(5'h0C, 32'h1, 2'b00);
    rd("coll_set_wins", 5'h0C, 2'b00, 32'd1);
    chk_irq("coll_irq_set", 1'b1);
    wr(5'h0C, 32'h1, 2'b00);
    rd("w1c_clears", 5'h0C, 2'b00, 32'd0);
    chk_irq("w1c_irq_drop", 1'b0);
    wr(5'h04, 32'h100, 2'b00);
    rd("count_write_wins", 5'h04, 2'b00, 32'h100);
    wr(5'h00, 32'h0, 2'b00);

    // wrap without match, match on next tick, then async reset
    wr(5'h0C, 32'h1, 2'b00);
    wr(5'h04, 32'hFFFF_FFFF, 2'b00);
    wr(5'h08, 32'd0, 2'b00);
    wr(5'h00, 32'h5, 2'b00);
    rd("wrap_count_max", 5'h04, 2'b00, 32'hFFFF_FFFF);
    cyc();
    rd("wrap_count_zero", 5'h04, 2'b00, 32'd0);
    rd("wrap_no_match", 5'h0C, 2'b00, 32'd0);
    cyc();
    rd("wrap_count_one", 5'h04, 2'b00, 32'd1);
    rd("wrap_match", 5'h0C, 2'b00, 32'd1);
    chk_irq("wrap_irq", 1'b1);
    #1;
    RST = 1'b0;
    #1;
    rd("rst_ctrl", 5'h00, 2'b00, 32'd0);
    rd("rst_count", 5'h04, 2'b00, 32'd0);
    rd("rst_status", 5'h0C, 2'b00, 32'd0);
    chk_irq("rst_irq", 1'b0);
    cyc();
    RST = 1'b1;
    cyc();
    cyc();
    rd("post_rst_idle", 5'h04, 2'b00, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_timer.md
# mmio_timer

Memory-mapped timer/compare peripheral that responds on the processor's data-memory bus, the same address/data/write-enable/size-select interface the processor drives toward the RAM. It decodes a parameterised address window, services word/half/byte reads and writes to its register file, and runs a prescaled up-counter that raises a sticky match flag and an interrupt line when it reaches a programmed compare value. The top level instantiates it beside the RAM and selects its read data when the address falls in its window.

## Interface
- ADDRESS_WIDTH, 32, bus address width
- DATA_WIDTH, 32, bus data width
- BASE_ADDR, 32'hFFFF_0000, window base; window is 32 bytes, aligned to 32
- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous, active-low reset
- Addr  in  ADDRESS_WIDTH  byte address from processor
- Data  in  DATA_WIDTH  write data, least-significant-aligned
- W_EN  in  1  write strobe, sampled on CLK rise
- sel  in  2  access size: 00 word, 01 half, 10 byte, 11 treated as word
- Hit  out  1  combinational: Addr inside window
- Output_Data  out  DATA_WIDTH  combinational read data, 0 when Hit=0
- IRQ  out  1  registered-state interrupt: STATUS.MATCH & CTRL.IE

## Operation
- Register map (offset = Addr[4:0]): 0x00 CTRL {IE[2], AR[1], EN[0]}; 0x04 COUNT[31:0]; 0x08 COMPARE[31:0]; 0x0C STATUS {MATCH[0]}, write-1-to-clear; 0x10 PRESCALE[15:0]; 0x14-0x1C read 0, writes ignored.
- Reads: word read of selected register; half returns bits at Addr[1]*16 zero-extended; byte returns lane Addr[1:0] zero-extended.
- Writes: only when W_EN=1 and Hit=1. Half writes update lane Addr[1]; byte writes update lane Addr[1:0]; other bits retained. Unaligned word/half addresses: low address bits ignored (forced alignment).
- Prescaler PCNT (16 bit, internal): while EN=1, PCNT increments; when PCNT==PRESCALE it returns to 0 and emits a one-cycle tick. EN=0 holds PCNT and COUNT.
- On tick: if COUNT==COMPARE then MATCH<=1 and COUNT<=AR ? 0 : COUNT+1; else COUNT<=COUNT+1. COUNT wraps 0xFFFF_FFFF -> 0 silently.
- Writing CTRL with EN 0->1 clears PCNT.

## Timing
- Reset (RST low, async): CTRL, COUNT, COMPARE, STATUS, PRESCALE, PCNT = 0; IRQ=0. Output_Data/Hit remain combinational from Addr.
- Read latency 0 cycles (combinational), matching RAM behaviour for the multi-cycle processor.
- Write visible in Output_Data the cycle after the CLK edge that samples it.
- PRESCALE=P gives one tick every P+1 enabled cycles; first tick P+1 cycles after EN set.
- IRQ rises the cycle after the tick edge that sets MATCH (with IE=1).
- Collisions: bus write to COUNT on a tick edge -> write wins, tick increment dropped; W1C of MATCH on the edge that sets MATCH -> set wins; write to COMPARE on a tick edge -> comparison uses old COMPARE.
- RST asserted mid-count: all state cleared immediately; counting resumes only after software sets EN.

## Structure
- Shared package: register offset constants, CTRL bit indices, sel encodings (SEL_WORD/HALF/BYTE), shared with RAM's size decode.
- One sub-module natural: mmio_lane_merge (combinational byte/half lane insert for writes and extract for reads), reusable by RAM.
- Remainder: address decode, register file, prescaler/counter FSM-free datapath in one module.

## Test plan
- Reset then word read of every offset 0x00-0x1C -> all 0, IRQ=0; Addr outside window -> Hit=0, Output_Data=0.
- Write COMPARE=5, PRESCALE=0, CTRL=0x5 -> COUNT 0..5 over 6 cycles, MATCH=1 and IRQ=1 on 7th cycle, COUNT=6 (AR=0).
- AR=1, COMPARE=3, PRESCALE=2 -> COUNT sequence 0,1,2,3,0 with each step every 3 cycles; MATCH set at 3->0 wrap.
- Byte write 0xAB to offset 0x05 over COUNT=0x11223344 (EN=0) -> COUNT=0x1122AB44; half read at 0x06 -> 0x00001122.
- Write STATUS=1 on the same edge a new match occurs -> MATCH stays 1; next W1C clears it, IRQ drops following cycle.
- COUNT=0xFFFF_FFFF, COMPARE=0, EN=1, PRESCALE=0 -> wraps to 0, no match at wrap; match on next tick, COUNT=1; assert RST mid-run -> all registers 0 asynchronously.
